// File: rtl/adc_ring_scheduler_pkg.sv
// Shared definitions for the ADC ring scheduler: FSM encoding, mode selectors and the
// default memory map also used by the VGA and CPU code.
package adc_ring_scheduler_pkg;

    // Writer FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    // Scheduling modes
    localparam int unsigned MODE_BURST = 0;
    localparam int unsigned MODE_RR    = 1;

    // Default sample ring placement in the shared data RAM
    localparam int unsigned DEFAULT_BASE_ADDR = 32'h801;
    localparam int unsigned DEFAULT_DEPTH     = 640;

    // Ceiling log2, never below 1 so that single-entry ranges still get a real bit
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_ring_scheduler_if.sv
// RAM port B bundle shared between the sample writer and the VGA reader.
interface adc_ring_scheduler_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 12
);
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_stall;

    // Scheduler side owns the RAM port; the reader supplies its address
    modport master (output ram_we, ram_addr, ram_din, rd_stall, input rd_addr);
    modport slave  (input ram_we, ram_addr, ram_din, rd_stall, output rd_addr);
endinterface

// File: rtl/adc_ring_scheduler_sample_tick_gen.sv
// Free-running sample interval counter producing a single-cycle tick.
module sample_tick_gen
    import adc_ring_scheduler_pkg::*;
#(
    parameter int unsigned SAMPLE_INTERVAL = 125000,
    localparam int unsigned CNT_W = clog2(SAMPLE_INTERVAL)
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    logic [CNT_W-1:0] count_q;
    logic             at_end;

    assign at_end = (count_q == CNT_W'(SAMPLE_INTERVAL - 1));
    assign tick   = enable && at_end;

    // Count 0..SAMPLE_INTERVAL-1 while enabled, hold otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= at_end ? '0 : count_q + 1'b1;
        end
    end
endmodule

// File: rtl/adc_ring_scheduler.sv
// Multi-channel ADC sample scheduler: snapshots channels on each tick and writes them into
// per-channel circular regions of the shared RAM, handing port B back to the VGA reader when idle.
module adc_ring_scheduler
    import adc_ring_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned ADDR_W          = 12,
    parameter int unsigned DEPTH           = DEFAULT_DEPTH,
    parameter int unsigned BASE_ADDR       = DEFAULT_BASE_ADDR,
    parameter int unsigned SAMPLE_INTERVAL = 125000,
    parameter int unsigned MODE            = MODE_BURST,
    localparam int unsigned PTR_W = clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     clr_overrun,
    adc_ring_scheduler_if.master     bus,
    output logic [NUM_CH*PTR_W-1:0]  wr_ptr,
    output logic [NUM_CH-1:0]        wrap_pulse,
    output logic                     overrun
);
    localparam int unsigned CH_W = clog2(NUM_CH);
    localparam int unsigned SUM_W = ADDR_W + 1;

    if ((BASE_ADDR + NUM_CH * DEPTH > 2 ** ADDR_W) || (SAMPLE_INTERVAL < 2)) begin : g_bad_cfg
        $error("adc_ring_scheduler: rings exceed address space or interval below 2");
    end

    logic              tick;
    logic [0:0]        state_q;
    logic [CH_W-1:0]   ch_idx_q;
    logic [CH_W-1:0]   rr_idx_q;
    logic [DATA_W-1:0] snap_q [NUM_CH];
    logic [PTR_W-1:0]  ptr_q  [NUM_CH];
    logic [NUM_CH-1:0] wrap_q;
    logic              overrun_q;
    logic [SUM_W-1:0]  wr_addr_full;
    logic              unused_addr_msb;

    sample_tick_gen #(
        .SAMPLE_INTERVAL(SAMPLE_INTERVAL)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .tick  (tick)
    );

    // Wide sum so an oversized map cannot silently alias inside the adder
    assign wr_addr_full = SUM_W'(BASE_ADDR) + SUM_W'(ch_idx_q) * SUM_W'(DEPTH)
                        + SUM_W'(ptr_q[ch_idx_q]);
    assign unused_addr_msb = wr_addr_full[ADDR_W];

    // Capture all channels on an accepted tick; ticks during a burst are dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) snap_q[c] <= '0;
        end else if (state_q == ST_IDLE && tick) begin
            for (int c = 0; c < NUM_CH; c++) snap_q[c] <= ch_data[c*DATA_W +: DATA_W];
        end
    end

    // Writer FSM, ring pointers, wrap pulses and sticky overrun
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ch_idx_q  <= '0;
            rr_idx_q  <= '0;
            wrap_q    <= '0;
            overrun_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) ptr_q[c] <= '0;
        end else begin
            wrap_q <= '0;
            if (tick && state_q == ST_WRITE) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q  <= ST_WRITE;
                        ch_idx_q <= (MODE == MODE_RR) ? rr_idx_q : '0;
                    end
                end
                ST_WRITE: begin
                    if (ptr_q[ch_idx_q] == PTR_W'(DEPTH - 1)) begin
                        ptr_q[ch_idx_q]  <= '0;
                        wrap_q[ch_idx_q] <= 1'b1;
                    end else begin
                        ptr_q[ch_idx_q] <= ptr_q[ch_idx_q] + 1'b1;
                    end
                    if (MODE == MODE_RR) begin
                        rr_idx_q <= (rr_idx_q == CH_W'(NUM_CH - 1)) ? '0 : rr_idx_q + 1'b1;
                        state_q  <= ST_IDLE;
                    end else if (ch_idx_q == CH_W'(NUM_CH - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        ch_idx_q <= ch_idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Port B mux: writer owns the port during WRITE; ram_din stays on the last snapshot
    always_comb begin
        bus.ram_we   = (state_q == ST_WRITE);
        bus.rd_stall = (state_q == ST_WRITE);
        bus.ram_addr = (state_q == ST_WRITE) ? wr_addr_full[ADDR_W-1:0] : bus.rd_addr;
        bus.ram_din  = snap_q[ch_idx_q];
    end

    // Flatten pointer array onto the export bus
    always_comb begin
        wr_ptr = '0;
        for (int c = 0; c < NUM_CH; c++) wr_ptr[c*PTR_W +: PTR_W] = ptr_q[c];
    end

    assign wrap_pulse = wrap_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_adc_ring_scheduler.sv
// Scoreboard bench: two schedulers (burst with overruns, round-robin) driven by shared random
// stimulus and checked against a transaction-level model of the sampling rules.
module tb_adc_ring_scheduler;
    localparam int NCH  = 3;
    localparam int DW   = 16;
    localparam int AW   = 12;
    localparam int DEP  = 4;
    localparam int PW   = 2;
    localparam int BASE = 'h801;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            ch;
        bit            wrap;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              clr_overrun = 1'b0;
    logic [AW-1:0]     rd_addr = '0;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH*PW-1:0] wr_ptr_a, wr_ptr_b;
    logic [NCH-1:0]    wrap_a, wrap_b;
    logic              ov_a, ov_b;

    adc_ring_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    adc_ring_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
    assign bus_a.rd_addr = rd_addr;
    assign bus_b.rd_addr = rd_addr;

    adc_ring_scheduler #(
        .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .BASE_ADDR(BASE),
        .SAMPLE_INTERVAL(3), .MODE(0)
    ) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .ch_data(ch_data),
        .clr_overrun(clr_overrun), .bus(bus_a), .wr_ptr(wr_ptr_a), .wrap_pulse(wrap_a),
        .overrun(ov_a)
    );

    adc_ring_scheduler #(
        .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .BASE_ADDR(BASE),
        .SAMPLE_INTERVAL(4), .MODE(1)
    ) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .ch_data(ch_data),
        .clr_overrun(clr_overrun), .bus(bus_b), .wr_ptr(wr_ptr_b), .wrap_pulse(wrap_b),
        .overrun(ov_b)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = burst DUT, 1 = round-robin DUT
    int   si [2];
    int   mode [2];
    int   cnt [2];
    int   wl [2];          // write cycles remaining, current cycle included
    int   rr [2];
    bit   ov [2];
    int   ptr [2][NCH];
    exp_t q_a[$];
    exp_t q_b[$];

    // Monitor-side state
    logic [NCH-1:0] wrap_next [2];
    logic [DW-1:0]  prev_din [2];
    bit             idle_ok [2];

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_ptr(input int d, input int c);
        logic [NCH*PW-1:0] v;
        v = (d == 0) ? wr_ptr_a : wr_ptr_b;
        return 32'((v >> (c * PW)) & 3);
    endfunction

    task automatic push(input int d, input int c);
        exp_t e;
        e.addr = AW'(BASE + c * DEP + ptr[d][c]);
        e.data = ch_data[c*DW +: DW];
        e.ch   = c;
        e.wrap = (ptr[d][c] == DEP - 1);
        ptr[d][c] = (ptr[d][c] + 1) % DEP;
        if (d == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    // Applies the sampling rules for the upcoming clock edge using the inputs just driven
    task automatic model(input int d);
        bit tick, busy;
        tick = enable && (cnt[d] == si[d] - 1);
        if (reset) begin
            cnt[d] = 0; wl[d] = 0; rr[d] = 0; ov[d] = 0;
            for (int c = 0; c < NCH; c++) ptr[d][c] = 0;
            if (d == 0) q_a.delete();
            else q_b.delete();
            return;
        end
        busy = (wl[d] > 0);
        if (busy) wl[d]--;
        if (tick && busy) ov[d] = 1;
        else if (clr_overrun) ov[d] = 0;
        if (tick && !busy) begin
            if (mode[d] == 0) begin
                for (int c = 0; c < NCH; c++) push(d, c);
                wl[d] = NCH;
            end else begin
                push(d, rr[d]);
                rr[d] = (rr[d] + 1) % NCH;
                wl[d] = 1;
            end
        end
        if (enable) cnt[d] = (cnt[d] == si[d] - 1) ? 0 : cnt[d] + 1;
    endtask

    task automatic monitor(input int d, input logic we, input logic stall,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din,
                           input logic [NCH-1:0] wrap);
        exp_t e;
        int   qs;
        chk("wrap_pulse", d, 32'(wrap), reset ? 32'd0 : 32'(wrap_next[d]));
        wrap_next[d] = '0;
        chk("rd_stall", d, 32'(stall), 32'(we));
        if (reset) begin
            chk("we_after_reset", d, 32'(we), 0);
            prev_din[d] = din;
            idle_ok[d]  = 1;
            return;
        end
        if (we) begin
            qs = (d == 0) ? q_a.size() : q_b.size();
            chk("write_expected", d, 32'(qs != 0), 1);
            if (qs != 0) begin
                e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                chk("ram_addr", d, 32'(addr), 32'(e.addr));
                chk("ram_din", d, 32'(din), 32'(e.data));
                wrap_next[d] = e.wrap ? NCH'(1 << e.ch) : '0;
            end
            idle_ok[d] = 0;
        end else begin
            chk("idle_addr", d, 32'(addr), 32'(rd_addr));
            if (idle_ok[d]) chk("idle_din_stable", d, 32'(din), 32'(prev_din[d]));
            prev_din[d] = din;
            idle_ok[d]  = 1;
        end
    endtask

    always @(negedge clock) begin
        monitor(0, bus_a.ram_we, bus_a.rd_stall, bus_a.ram_addr, bus_a.ram_din, wrap_a);
        monitor(1, bus_b.ram_we, bus_b.rd_stall, bus_b.ram_addr, bus_b.ram_din, wrap_b);
    end

    // One clock of stimulus: check settled state, drive inputs, advance the model
    task automatic step(input bit rst, input bit en, input bit clr);
        @(negedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("overrun", d, 32'((d == 0) ? ov_a : ov_b), 32'(ov[d]));
            if (wl[d] == 0) begin
                for (int c = 0; c < NCH; c++) chk("wr_ptr", d, dut_ptr(d, c), 32'(ptr[d][c]));
            end
        end
        reset       = rst;
        enable      = en;
        clr_overrun = clr;
        rd_addr     = AW'($urandom);
        ch_data     = (NCH*DW)'({$urandom, $urandom});
        model(0);
        model(1);
    endtask

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        bit found;
        si[0] = 3; si[1] = 4; mode[0] = 0; mode[1] = 1;
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0; wl[d] = 0; rr[d] = 0; ov[d] = 0;
            wrap_next[d] = '0; prev_din[d] = '0; idle_ok[d] = 0;
            for (int c = 0; c < NCH; c++) ptr[d][c] = 0;
        end

        repeat (3) step(1, 0, 0);
        random_steps(300);

        // Reset landing in the middle of a burst on the burst-mode writer
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (wl[0] >= 2) found = 1;
            else step(0, 1, 0);
        end
        chk("burst_found", 0, 32'(found), 1);
        step(1, 1, 0);

        // Enable low: no ticks, no writes
        repeat (50) step(0, 0, $urandom_range(0, 1) == 1);

        random_steps(300);
        repeat (20) step(0, 0, 0);

        chk("queue_drained", 0, 32'(q_a.size()), 0);
        chk("queue_drained", 1, 32'(q_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
